// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, default geometry and width helpers for the instruction cache
package icache_pkg;
  typedef enum logic [2:0] {IDLE, REQ, FILL, DONE, DRAIN} state_e;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_WAYS = 2;
  localparam int DEF_SETS = 64;
  localparam int DEF_WORDS = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  // way-select and age fields keep at least one bit so WAYS=1 still elaborates
  function automatic int sel_w(input int ways);
    return ways > 1 ? clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/icache_lru.sv
// icache_lru: true-LRU age update and victim selection for one set
module icache_lru import icache_pkg::*; #(
  parameter int WAYS = DEF_WAYS,
  parameter int SW = sel_w(WAYS)
) (
  input  logic [WAYS-1:0]    valid_i,
  input  logic [WAYS*SW-1:0] age_i,
  input  logic [SW-1:0]      way_i,
  input  logic               install_i,
  output logic [WAYS*SW-1:0] age_o,
  output logic [SW-1:0]      victim_o
);
  logic [SW-1:0] old;
  // touched way becomes youngest; ways younger than its old age grow one step older
  always_comb begin
    old = install_i ? SW'(WAYS - 1) : age_i[way_i*SW +: SW];
    age_o = '0;
    for (int w = 0; w < WAYS; w++)
      age_o[w*SW +: SW] = (SW'(w) == way_i) ? '0 :
                          (age_i[w*SW +: SW] < old) ? age_i[w*SW +: SW] + SW'(1) : age_i[w*SW +: SW];
  end
  // lowest invalid way wins, otherwise the oldest way
  always_comb begin
    victim_o = '0;
    for (int w = WAYS - 1; w >= 0; w--) if (age_i[w*SW +: SW] == SW'(WAYS - 1)) victim_o = SW'(w);
    for (int w = WAYS - 1; w >= 0; w--) if (!valid_i[w]) victim_o = SW'(w);
  end
endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative read-only instruction cache with line fill, LRU and hit/miss counters
module icache_assoc import icache_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS,
  parameter int WORDS = DEF_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);
  localparam int OFF_W = clog2(WORDS);
  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
  localparam int SW = sel_w(WAYS);
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx, sel_idx;
  logic [TAG_W-1:0] tag;
  logic unused_addr_lsb;
  logic [SETS-1:0][WAYS-1:0] valid_mem;
  logic [SETS-1:0][WAYS*SW-1:0] age_mem;
  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS][WORDS];
  state_e state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] mtag_q, mtag_d;
  logic [SW-1:0] victim_q, victim_d;
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic hit_any, hit, miss_go, last_beat;
  logic [SW-1:0] hit_way, victim;
  logic [WAYS*SW-1:0] age_nx;
  assign off = cpu_addr[OFF_W:1];
  assign idx = cpu_addr[OFF_W+IDX_W:OFF_W+1];
  assign tag = cpu_addr[ADDR_W-1:OFF_W+IDX_W+1];
  assign unused_addr_lsb = cpu_addr[0];
  // tag compare across all ways of the addressed set
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_mem[idx][w] && tag_mem[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = SW'(w);
      end
  end
  assign hit = state_q == IDLE && hit_any;
  assign cpu_rdata = hit ? data_mem[idx][hit_way][off] : '0;
  assign stall = rst_n & cpu_req & ~hit;
  assign mem_req = state_q == REQ;
  assign mem_addr = mem_req ? {mtag_q, idx_q, {(OFF_W + 1){1'b0}}} : '0;
  assign hit_cnt = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign miss_go = state_q == IDLE && cpu_req && !hit && !flush;
  assign last_beat = mem_rvalid && beat_q == OFF_W'(WORDS - 1);
  assign sel_idx = state_q == DONE ? idx_q : idx;
  icache_lru #(.WAYS(WAYS), .SW(SW)) u_lru (
    .valid_i  (valid_mem[sel_idx]),
    .age_i    (age_mem[sel_idx]),
    .way_i    (state_q == DONE ? victim_q : hit_way),
    .install_i(state_q == DONE),
    .age_o    (age_nx),
    .victim_o (victim)
  );
  // line-fill sequencing and saturating counters
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    idx_d = idx_q;
    mtag_d = mtag_q;
    victim_d = victim_q;
    hit_cnt_d = (cpu_req && hit && hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 16'd1 : hit_cnt_q;
    miss_cnt_d = (miss_go && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
    case (state_q)
      IDLE: if (miss_go) begin
        state_d = REQ;
        idx_d = idx;
        mtag_d = tag;
        victim_d = victim;
      end
      REQ: state_d = flush ? DRAIN : FILL;
      FILL: begin
        beat_d = mem_rvalid ? beat_q + 1'b1 : beat_q;
        state_d = last_beat ? (flush ? IDLE : DONE) : (flush ? DRAIN : FILL);
      end
      DONE: state_d = IDLE;
      DRAIN: begin
        beat_d = mem_rvalid ? beat_q + 1'b1 : beat_q;
        state_d = last_beat ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  // control and counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q <= '0;
      idx_q <= '0;
      mtag_q <= '0;
      victim_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      idx_q <= idx_d;
      mtag_q <= mtag_d;
      victim_q <= victim_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  // valid bits and ages: flush wipes everything, install and hits refresh LRU
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_mem <= '0;
      age_mem <= '0;
    end else if (flush) begin
      valid_mem <= '0;
      age_mem <= '0;
    end else begin
      if (state_q == DONE) valid_mem[idx_q][victim_q] <= 1'b1;
      if (state_q == DONE || (cpu_req && hit)) age_mem[sel_idx] <= age_nx;
    end
  // line payload: beats land in the victim during the fill, tag lands at install
  always_ff @(posedge clk) begin
    if (state_q == FILL && mem_rvalid) data_mem[idx_q][victim_q][beat_q] <= mem_rdata;
    if (state_q == DONE) tag_mem[idx_q][victim_q] <= mtag_q;
  end
endmodule
